// File: rtl/sdtxseq_pkg.sv
// Shared encodings for the SDIO write-data sequencer: FSM states, CRC status
// tokens and completion error codes.
package sdtxseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_WAIT_CRC  = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [2:0] TOK_ACCEPT = 3'b010;
    localparam logic [2:0] TOK_CRCERR = 3'b101;

    localparam logic [1:0] ERR_ABORT   = 2'b00;
    localparam logic [1:0] ERR_CRC     = 2'b01;
    localparam logic [1:0] ERR_WRITE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/sdtxseq_fifo.sv
// Two-entry skid FIFO between the block-buffer read port and the framer stream.
// Flush empties it in one edge and wins over a same-cycle push.
module sdtxseq_fifo #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_rdata,
    output logic [1:0]   o_count
);

    logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    always_comb begin
        pop      = (count_q != 2'd0) && i_ready;
        push     = i_wr && ((count_q != 2'd2) || pop);
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) mem1_d = i_wdata;
                else          mem0_d = i_wdata;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_valid = (count_q != 2'd0);
    assign o_rdata = rd_ptr_q ? mem1_q : mem0_q;
    assign o_count = count_q;

endmodule

// File: rtl/sdtxseq.sv
// SDIO write-data sequencer: streams each block from the word buffer into the
// TX framer, then waits for the card's CRC token and DAT0 busy release.
module sdtxseq
    import sdtxseq_pkg::*;
#(
    parameter int ADDRW     = 8,
    parameter int LGTIMEOUT = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [15:0]          i_nblocks,
    input  logic [3:0]           i_lgblk,
    input  logic [LGTIMEOUT-1:0] i_cfg_timeout,
    output logic                 o_mem_rd,
    output logic [ADDRW-1:0]     o_mem_addr,
    input  logic [31:0]          i_mem_data,
    output logic                 o_tx_en,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic [31:0]          M_DATA,
    output logic                 M_LAST,
    input  logic                 i_tx_busy,
    input  logic                 i_crc_valid,
    input  logic [2:0]           i_crc_status,
    input  logic                 i_card_busy,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [1:0]           o_errcode,
    output logic [15:0]          o_blocks_done,
    output logic [2:0]           o_dbg_state
);

    // Stream handshake: a word transfers on every edge where M_VALID && M_READY;
    // while M_VALID && !M_READY the FIFO head, hence M_DATA/M_LAST, cannot move.

    state_t               state_q, state_d;
    logic [ADDRW-1:0]     addr_q, addr_d;
    logic [ADDRW:0]       reads_left_q, reads_left_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_last_q, rd_last_d;
    logic [15:0]          nblocks_q, nblocks_d;
    logic [3:0]           lgblk_q, lgblk_d;
    logic [LGTIMEOUT-1:0] cfg_timeout_q, cfg_timeout_d;
    logic [LGTIMEOUT-1:0] timer_q, timer_d;
    logic [15:0]          blocks_done_q, blocks_done_d;
    logic                 err_q, err_d;
    logic [1:0]           errcode_q, errcode_d;

    logic        fifo_valid;
    logic [32:0] fifo_rdata;
    logic [1:0]  fifo_count;
    logic        pop, abort, mem_rd, timer_expired;
    logic [2:0]  occupancy;

    function automatic logic [ADDRW:0] words_per_block(input logic [3:0] lgblk);
        return (ADDRW+1)'(1) << (lgblk - 4'd2);
    endfunction

    sdtxseq_fifo #(.W(33)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (abort),
        .i_wr    (rd_pend_q),
        .i_wdata ({rd_last_q, i_mem_data}),
        .o_valid (fifo_valid),
        .i_ready (M_READY),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count)
    );

    always_comb begin
        pop           = fifo_valid && M_READY;
        abort         = i_abort && (state_q inside {ST_STREAM, ST_WAIT_CRC, ST_WAIT_BUSY});
        // A timer loaded with N allows N wait cycles; 0 and 1 both expire now.
        timer_expired = (timer_q <= LGTIMEOUT'(1));
        // Occupancy after this cycle's pop, so one word per cycle is sustained.
        occupancy     = 3'(fifo_count) - 3'(pop) + 3'(rd_pend_q);
        mem_rd        = (state_q == ST_STREAM) && !abort
                        && (reads_left_q != '0) && (occupancy < 3'd2);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        reads_left_d  = reads_left_q;
        rd_pend_d     = mem_rd;
        rd_last_d     = mem_rd && (reads_left_q == (ADDRW+1)'(1));
        nblocks_d     = nblocks_q;
        lgblk_d       = lgblk_q;
        cfg_timeout_d = cfg_timeout_q;
        timer_d       = timer_q;
        blocks_done_d = blocks_done_q;
        err_d         = err_q;
        errcode_d     = errcode_q;
        o_done        = 1'b0;

        if (mem_rd) begin
            addr_d       = addr_q + ADDRW'(1);
            reads_left_d = reads_left_q - (ADDRW+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    nblocks_d     = i_nblocks;
                    lgblk_d       = i_lgblk;
                    cfg_timeout_d = i_cfg_timeout;
                    addr_d        = '0;
                    blocks_done_d = '0;
                    err_d         = 1'b0;
                    errcode_d     = ERR_ABORT;
                    reads_left_d  = words_per_block(i_lgblk);
                    state_d       = (i_nblocks == 16'd0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop && fifo_rdata[32]) begin
                    state_d = ST_WAIT_CRC;
                    timer_d = cfg_timeout_q;
                end
            end
            ST_WAIT_CRC: begin
                if (i_crc_valid) begin
                    if (i_crc_status == TOK_ACCEPT) begin
                        state_d = ST_WAIT_BUSY;
                        timer_d = cfg_timeout_q;
                    end else begin
                        state_d   = ST_DONE;
                        err_d     = 1'b1;
                        errcode_d = (i_crc_status == TOK_CRCERR) ? ERR_CRC : ERR_WRITE;
                    end
                end else if (timer_expired) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    errcode_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - LGTIMEOUT'(1);
                end
            end
            ST_WAIT_BUSY: begin
                if (!i_tx_busy && !i_card_busy) begin
                    blocks_done_d = blocks_done_q + 16'd1;
                    reads_left_d  = words_per_block(lgblk_q);
                    state_d       = (blocks_done_d == nblocks_q) ? ST_DONE : ST_STREAM;
                end else if (timer_expired) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    errcode_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - LGTIMEOUT'(1);
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_DONE;
            err_d     = 1'b1;
            errcode_d = ERR_ABORT;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            reads_left_q  <= '0;
            rd_pend_q     <= 1'b0;
            rd_last_q     <= 1'b0;
            nblocks_q     <= '0;
            lgblk_q       <= '0;
            cfg_timeout_q <= '0;
            timer_q       <= '0;
            blocks_done_q <= '0;
            err_q         <= 1'b0;
            errcode_q     <= ERR_ABORT;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            reads_left_q  <= reads_left_d;
            rd_pend_q     <= rd_pend_d;
            rd_last_q     <= rd_last_d;
            nblocks_q     <= nblocks_d;
            lgblk_q       <= lgblk_d;
            cfg_timeout_q <= cfg_timeout_d;
            timer_q       <= timer_d;
            blocks_done_q <= blocks_done_d;
            err_q         <= err_d;
            errcode_q     <= errcode_d;
        end
    end

    assign o_mem_rd      = mem_rd;
    assign o_mem_addr    = addr_q;
    assign o_tx_en       = (state_q == ST_STREAM);
    assign M_VALID       = fifo_valid;
    assign M_DATA        = fifo_rdata[31:0];
    assign M_LAST        = fifo_valid && fifo_rdata[32];
    assign o_busy        = (state_q != ST_IDLE);
    assign o_err         = err_q;
    assign o_errcode     = errcode_q;
    assign o_blocks_done = blocks_done_q;
    assign o_dbg_state   = state_q;

endmodule
